// File: rtl/shl2_pkg.sv
// shl2_pkg: shared constants and signed-overflow rule for the x4 shifter and ALU
package shl2_pkg;
  localparam int DEFAULT_WIDTH = 32;
  localparam int SHIFT_AMT = 2;
  function automatic logic shl2_ovf(input logic [2:0] top3);
    return !(top3 == 3'b000 || top3 == 3'b111);
  endfunction
endpackage

// File: rtl/shl2_out_reg.sv
// shl2_out_reg: W-bit register with synchronous active-high reset and load enable
module shl2_out_reg #(
  parameter int W = 36
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_en,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);
  logic [W-1:0] r_q;
  always_ff @(posedge i_clk) r_q <= i_rst ? '0 : i_en ? i_d : r_q;
  assign o_q = r_q;
endmodule

// File: rtl/shift_left_by_2.sv
// shift_left_by_2: x*4 logical shift with lost bits, signed overflow and optional output register
module shift_left_by_2
  import shl2_pkg::*;
#(
  parameter int WIDTH   = DEFAULT_WIDTH,
  parameter int LATENCY = 0
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data,
  output logic [1:0]       o_lost,
  output logic             o_ovf
);
  logic [WIDTH+2:0] w_res;
  assign w_res = {i_data[WIDTH-1 -: 2], shl2_ovf(i_data[WIDTH-1 -: 3]),
                  i_data[WIDTH-SHIFT_AMT-1:0], {SHIFT_AMT{1'b0}}};
  if (WIDTH < 3 || (LATENCY != 0 && LATENCY != 1)) begin : g_bad
    $fatal(1, "shift_left_by_2: need WIDTH >= 3 and LATENCY in {0,1}");
  end
  if (LATENCY == 1) begin : g_reg
    logic [WIDTH+3:0] w_q;
    shl2_out_reg #(.W(WIDTH + 4)) u_reg (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .i_en  (i_valid | w_q[WIDTH+3]),
      .i_d   ({i_valid, i_valid ? w_res : w_q[WIDTH+2:0]}),
      .o_q   (w_q)
    );
    assign {o_valid, o_lost, o_ovf, o_data} = w_q;
  end else begin : g_comb
    logic w_unused;
    assign w_unused = i_clk ^ i_rst;
    assign {o_valid, o_lost, o_ovf, o_data} = {i_valid, w_res};
  end
endmodule

// File: tb/tb_shift_left_by_2.sv
// tb_shift_left_by_2: scoreboard bench for the x4 shifter at LATENCY 0/1 and WIDTH 3
module tb_shift_left_by_2;
  typedef struct {logic [31:0] d; logic [1:0] l; logic o;} exp_t;
  logic clk = 0, rst = 1, i_valid = 0, i_valid3 = 0;
  logic [31:0] i_data = 0;
  logic [2:0] i_data3 = 0;
  logic v0, v1, v3, o0, o1, o3;
  logic [31:0] d0, d1;
  logic [2:0] d3;
  logic [1:0] l0, l1, l3;
  exp_t q0[$], q1[$], q3[$];
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  shift_left_by_2 #(.WIDTH(32), .LATENCY(0)) dut0 (.i_clk(clk), .i_rst(rst), .i_valid(i_valid),
    .i_data(i_data), .o_valid(v0), .o_data(d0), .o_lost(l0), .o_ovf(o0));
  shift_left_by_2 #(.WIDTH(32), .LATENCY(1)) dut1 (.i_clk(clk), .i_rst(rst), .i_valid(i_valid),
    .i_data(i_data), .o_valid(v1), .o_data(d1), .o_lost(l1), .o_ovf(o1));
  shift_left_by_2 #(.WIDTH(3), .LATENCY(0)) dut3 (.i_clk(clk), .i_rst(rst), .i_valid(i_valid3),
    .i_data(i_data3), .o_valid(v3), .o_data(d3), .o_lost(l3), .o_ovf(o3));
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", n, a, e);
    end
  endtask
  task automatic miss(input string n);
    checks++;
    errors++;
    $display("FAIL %s actual=output_valid expected=no_pending_word", n);
  endtask
  task automatic send(input logic r, input logic v, input logic [31:0] x, input logic [31:0] ed,
                      input logic [1:0] el, input logic eo);
    @(posedge clk);
    #1;
    rst = r;
    i_valid = v;
    i_data = x;
    if (v) q0.push_back(exp_t'{ed, el, eo});
    if (v && !r) q1.push_back(exp_t'{ed, el, eo});
  endtask
  always @(negedge clk) begin
    exp_t e;
    chk("l0_valid", {31'd0, v0}, {31'd0, i_valid});
    if (v0) begin
      if (q0.size() == 0) miss("l0_extra");
      else begin
        e = q0.pop_front();
        chk("l0_data", d0, e.d);
        chk("l0_lost", {30'd0, l0}, {30'd0, e.l});
        chk("l0_ovf", {31'd0, o0}, {31'd0, e.o});
      end
    end
    if (v1) begin
      if (q1.size() == 0) miss("l1_extra");
      else begin
        e = q1.pop_front();
        chk("l1_data", d1, e.d);
        chk("l1_lost", {30'd0, l1}, {30'd0, e.l});
        chk("l1_ovf", {31'd0, o1}, {31'd0, e.o});
      end
    end
    if (v3) begin
      if (q3.size() == 0) miss("w3_extra");
      else begin
        e = q3.pop_front();
        chk("w3_data", {29'd0, d3}, e.d);
        chk("w3_lost", {30'd0, l3}, {30'd0, e.l});
        chk("w3_ovf", {31'd0, o3}, {31'd0, e.o});
      end
    end
  end
  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [31:0] dv[10], de[10];
    logic [1:0] dl[10];
    logic dof[10];
    logic [2:0] t3d[8], t3l_d[8];
    logic [1:0] t3l[8];
    logic t3o[8];
    dv = '{32'd1, 32'd2, 32'd4, 32'd8, 32'd16, 32'd32, 32'hC000_0000, 32'hE000_0000,
           32'h2000_0000, 32'hFFFF_FFFF};
    de = '{32'd4, 32'd8, 32'd16, 32'd32, 32'd64, 32'd128, 32'h0, 32'h8000_0000,
           32'h8000_0000, 32'hFFFF_FFFC};
    dl = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b11, 2'b11, 2'b00, 2'b11};
    dof = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    t3d = '{3'd0, 3'd4, 3'd0, 3'd4, 3'd0, 3'd4, 3'd0, 3'd4};
    t3l = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3};
    t3o = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    t3l_d = t3d;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", {31'd0, v1}, 32'd0);
    chk("rst_data", d1, 32'd0);
    chk("rst_lost", {30'd0, l1}, 32'd0);
    chk("rst_ovf", {31'd0, o1}, 32'd0);
    send(1, 1, 32'h1234_5678, 32'h48D1_59E0, 2'b00, 1'b0);
    send(0, 1, 32'h1234_5678, 32'h48D1_59E0, 2'b00, 1'b0);
    @(negedge clk);
    chk("rst_prio_valid", {31'd0, v1}, 32'd0);
    chk("rst_prio_data", d1, 32'd0);
    send(0, 1, 32'd5, 32'd20, 2'b00, 1'b0);
    send(0, 0, 32'd7, 32'd0, 2'b00, 1'b0);
    send(0, 0, 32'd7, 32'd0, 2'b00, 1'b0);
    @(negedge clk);
    chk("hold_valid", {31'd0, v1}, 32'd0);
    chk("hold_data", d1, 32'd20);
    for (int i = 0; i < 10; i++) send(0, 1, dv[i], de[i], dl[i], dof[i]);
    send(0, 0, 32'd0, 32'd0, 2'b00, 1'b0);
    for (int i = 0; i < 2000; i++) begin
      logic [31:0] x;
      longint s;
      logic v;
      x = $urandom;
      v = $urandom_range(3) != 0;
      s = $signed(x);
      s = s * 4;
      send(0, v, x, x * 32'd4, 2'(x >> 30), s > 64'sd2147483647 || s < -64'sd2147483648);
    end
    send(0, 0, 32'd0, 32'd0, 2'b00, 1'b0);
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      i_valid3 = 1;
      i_data3 = 3'(i);
      q3.push_back(exp_t'{{29'd0, t3l_d[i]}, t3l[i], t3o[i]});
    end
    @(posedge clk);
    #1;
    i_valid3 = 0;
    repeat (3) send(0, 0, 32'd0, 32'd0, 2'b00, 1'b0);
    @(negedge clk);
    chk("q0_drain", q0.size(), 32'd0);
    chk("q1_drain", q1.size(), 32'd0);
    chk("q3_drain", q3.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
